// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the memory-mapped timer.
// Register offsets (addr[3:2]) and CTRL/STATUS bit positions.
package timer_pkg;

    localparam logic [1:0] TMR_COUNT  = 2'd0;
    localparam logic [1:0] TMR_CMP    = 2'd1;
    localparam logic [1:0] TMR_CTRL   = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    // CTRL bits
    localparam int EN           = 0;
    localparam int CLR_ON_MATCH = 1;
    localparam int MIE          = 2;
    localparam int OIE          = 3;

    // STATUS bits
    localparam int MATCH = 0;
    localparam int OVF   = 1;

    localparam logic [3:0] CTRL_RST = 4'b0001;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides CLK down to a one-cycle tick every DIV cycles.
// Ports: CLK, RESET (sync, high), en (count enable), clr (restart), tick.
module timer_prescaler #(
    parameter int DIV = 10
) (
    input  logic CLK,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick = en && (pre_q == PW'(DIV - 1));

    // Disabling holds pre so a re-enable resumes mid-period.
    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/timer_mmio.sv
// timer_mmio: prescaled MMIO timer with compare, overflow flags and irq.
// Ports: CLK, RESET, bus (sel, we, addr, wdata, rdata), irq, Do (COUNT lag).
module timer_mmio
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int WIDTH   = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             sel,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq,
    output logic [WIDTH-1:0] Do
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
        $error("timer_mmio: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
        $error("timer_mmio: WIDTH must be 8..32");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [1:0]       status_q, status_d;
    logic [31:0]      rdata_q, rd_val;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] do_q;

    logic       wr, rd, cnt_wr, tick, hit, clr_hit;
    logic [1:0] reg_sel, set_v;
    logic       unused_bits;

    assign reg_sel     = addr[3:2];
    assign wr          = sel & we;
    assign rd          = sel & ~we;
    assign cnt_wr      = wr && (reg_sel == TMR_COUNT);
    assign unused_bits = ^{addr[1:0], wdata};

    timer_prescaler #(
        .DIV(DIV)
    ) u_pre (
        .CLK  (CLK),
        .RESET(RESET),
        .en   (ctrl_q[EN]),
        .clr  (cnt_wr),
        .tick (tick)
    );

    assign hit     = tick && (count_q == cmp_q);
    assign clr_hit = hit && ctrl_q[CLR_ON_MATCH];

    // A clear-on-match to zero is not an overflow, even with CMP all-ones.
    always_comb begin
        set_v        = '0;
        set_v[MATCH] = hit;
        set_v[OVF]   = tick && !clr_hit && (&count_q);
    end

    always_comb begin
        count_d  = count_q;
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        status_d = status_q;
        if (tick) begin
            count_d = clr_hit ? '0 : count_q + 1'b1;
        end
        // Bus writes override the tick; flag sets override W1C.
        if (wr) begin
            unique case (reg_sel)
                TMR_COUNT:  count_d  = wdata[WIDTH-1:0];
                TMR_CMP:    cmp_d    = wdata[WIDTH-1:0];
                TMR_CTRL:   ctrl_d   = wdata[3:0];
                TMR_STATUS: status_d = status_q & ~wdata[1:0];
            endcase
        end
        status_d = status_d | set_v;
    end

    always_comb begin
        rd_val = '0;
        unique case (reg_sel)
            TMR_COUNT:  rd_val = 32'(count_q);
            TMR_CMP:    rd_val = 32'(cmp_q);
            TMR_CTRL:   rd_val = 32'(ctrl_q);
            TMR_STATUS: rd_val = 32'(status_q);
        endcase
    end

    assign irq_d = (status_q[MATCH] & ctrl_q[MIE])
                 | (status_q[OVF] & ctrl_q[OIE]);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q  <= '0;
            cmp_q    <= '1;
            ctrl_q   <= CTRL_RST;
            status_q <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            do_q     <= '0;
        end else begin
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            if (rd) begin
                rdata_q <= rd_val;
            end
            irq_q <= irq_d;
            do_q  <= count_q;
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;
    assign Do    = do_q;

endmodule

// File: tb/tb_timer_mmio.sv
// tb_timer_mmio: directed and random stimulus for timer_mmio (DIV=10, WIDTH=8)
// checked every cycle against an arithmetic reference model.
module tb_timer_mmio;

    localparam int DIV = 10;

    logic        CLK;
    logic        RESET;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  Do;

    int total = 0;
    int bad   = 0;

    // Reference model state, plain integers.
    int m_pre, m_count, m_cmp, m_ctrl, m_status;
    int m_rdata, m_irq, m_do;

    timer_mmio #(
        .CLK_HZ (10),
        .TICK_HZ(1),
        .WIDTH  (8)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .sel  (sel),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq),
        .Do   (Do)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int regval(input int r);
        case (r)
            0:       return m_count;
            1:       return m_cmp;
            2:       return m_ctrl;
            default: return m_status;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit s, input bit w,
                              input logic [3:0] a, input logic [31:0] d);
        int  r, n_count, n_status, n_pre, setb;
        bit  tick, hit, clr;
        if (rst) begin
            m_pre = 0; m_count = 0; m_cmp = 255; m_ctrl = 1;
            m_status = 0; m_rdata = 0; m_irq = 0; m_do = 0;
            return;
        end
        r    = int'(a[3:2]);
        tick = (m_ctrl % 2 == 1) && (m_pre == DIV - 1);
        hit  = tick && (m_count == m_cmp);
        clr  = hit && ((m_ctrl / 2) % 2 == 1);
        n_count = m_count;
        if (tick) n_count = clr ? 0 : (m_count + 1) % 256;
        setb = (hit ? 1 : 0) + ((tick && !clr && m_count == 255) ? 2 : 0);
        if (s && !w) m_rdata = regval(r);
        m_irq = ((m_status % 2 == 1) && ((m_ctrl / 4) % 2 == 1)) ||
                ((m_status / 2 == 1) && (m_ctrl / 8 == 1)) ? 1 : 0;
        m_do = m_count;
        n_pre = m_pre;
        if (m_ctrl % 2 == 1) n_pre = tick ? 0 : m_pre + 1;
        n_status = m_status;
        if (s && w) begin
            case (r)
                0: begin n_count = int'(d[7:0]); n_pre = 0; end
                1: m_cmp = int'(d[7:0]);
                2: m_ctrl = int'(d[3:0]);
                default: n_status = n_status & ~int'(d[1:0]);
            endcase
        end
        m_count  = n_count;
        m_pre    = n_pre;
        m_status = n_status | setb;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit s, input bit w,
                       input logic [3:0] a, input logic [31:0] d);
        RESET = rst; sel = s; we = w; addr = a; wdata = d;
        @(posedge CLK);
        model_step(rst, s, w, a, d);
        #1;
        chk("do", {24'h0, Do}, 32'(m_do));
        chk("irq", {31'h0, irq}, 32'(m_irq));
        chk("rdata", rdata, 32'(m_rdata));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 4'h0, 32'h0);
    endtask

    task automatic rdreg(input logic [1:0] r);
        logic [1:0] lo;
        lo = 2'($urandom_range(3));
        cyc(0, 1, 0, {r, lo}, 32'($urandom));
    endtask

    task automatic wrreg(input logic [1:0] r, input logic [31:0] d);
        logic [1:0] lo;
        lo = 2'($urandom_range(3));
        cyc(0, 1, 1, {r, lo}, d);
    endtask

    // Idle until the model's prescaler reaches k (optionally at a match).
    task automatic wait_pre(input int k, input bit need_match,
                            input string tag);
        int n;
        n = 0;
        while (!(m_pre == k && (!need_match || m_count == m_cmp))
               && n < 300) begin
            idle();
            n++;
        end
        total++;
        assert (n < 300) else begin
            bad++;
            $error("FAIL %s timeout observed=%0d expected=<300", tag, n);
        end
    endtask

    initial begin
        int c;
        RESET = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;

        // Reset default: free-running count
        repeat (3) cyc(1, 1, 0, 4'h0, 32'h0);
        chk("rst_do", {24'h0, Do}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        repeat (35) idle();
        rdreg(2'd0);
        chk("cnt35", rdata, 32'd3);
        repeat (4) idle();
        chk("do_lag3", {24'h0, Do}, 32'd3);
        idle();
        chk("do_lag4", {24'h0, Do}, 32'd4);

        // Match with clear-on-match
        wrreg(2'd1, 32'd2);
        wrreg(2'd2, 32'h7);
        wrreg(2'd0, 32'd0);
        for (int k = 1; k <= 31; k++) begin
            rdreg(2'd0);
            if (k == 1)  chk("seq0", rdata, 32'd0);
            if (k == 11) chk("seq1", rdata, 32'd1);
            if (k == 21) chk("seq2", rdata, 32'd2);
            if (k == 30) chk("irq_pre", {31'h0, irq}, 32'd0);
            if (k == 31) begin
                chk("seq_wrap", rdata, 32'd0);
                chk("irq_match", {31'h0, irq}, 32'd1);
            end
        end
        rdreg(2'd3);
        chk("match_flag", rdata, 32'd1);
        wrreg(2'd3, 32'd1);
        chk("irq_hold", {31'h0, irq}, 32'd1);
        idle();
        chk("irq_w1c", {31'h0, irq}, 32'd0);

        // Overflow with CMP all-ones, no clear
        wrreg(2'd3, 32'h3);
        wrreg(2'd1, 32'hFF);
        wrreg(2'd2, 32'h9);
        wrreg(2'd0, 32'hFF);
        repeat (10) idle();
        rdreg(2'd0);
        chk("ovf_cnt", rdata, 32'd0);
        chk("ovf_irq", {31'h0, irq}, 32'd1);
        rdreg(2'd3);
        chk("ovf_status", rdata, 32'd3);

        // COUNT write on the tick edge
        wait_pre(DIV - 1, 1'b0, "sync_tick");
        wrreg(2'd0, 32'd5);
        rdreg(2'd0);
        chk("coll_cnt", rdata, 32'd5);
        repeat (8) idle();
        rdreg(2'd0);
        chk("coll_hold", rdata, 32'd5);
        rdreg(2'd0);
        chk("coll_inc", rdata, 32'd6);

        // W1C MATCH on the edge of a new match
        wrreg(2'd3, 32'h3);
        wrreg(2'd1, 32'd7);
        wait_pre(DIV - 1, 1'b1, "sync_match");
        wrreg(2'd3, 32'h1);
        rdreg(2'd3);
        chk("set_wins", rdata, 32'd1);

        // Disable at pre=4, hold, resume
        wait_pre(3, 1'b0, "sync_pre3");
        wrreg(2'd2, 32'h8);
        c = m_count;
        repeat (20) idle();
        rdreg(2'd0);
        chk("frozen", rdata, 32'(c));
        wrreg(2'd2, 32'h9);
        repeat (5) idle();
        rdreg(2'd0);
        chk("resume_hold", rdata, 32'(c));
        rdreg(2'd0);
        chk("resume_tick", rdata, 32'((c + 1) % 256));

        // Random bus traffic
        for (int i = 0; i < 400; i++) begin
            bit          s, w;
            logic [3:0]  a;
            logic [31:0] d;
            s = ($urandom_range(1) == 1);
            w = ($urandom_range(3) == 0);
            a = 4'($urandom);
            d = $urandom;
            if (a[3:2] == 2'd2) d[0] = ($urandom_range(3) != 0);
            if (a[3:2] == 2'd0 && $urandom_range(1) == 1) d[7:0] = 8'hFE;
            cyc(0, s, w, a, d);
        end

        // Reset mid-operation with irq high and a read pending
        wrreg(2'd2, 32'h9);
        wrreg(2'd0, 32'hFF);
        repeat (11) idle();
        chk("pre_rst_irq", {31'h0, irq}, 32'd1);
        cyc(1, 1, 0, 4'h1, 32'h0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_irq", {31'h0, irq}, 32'd0);
        chk("mid_rst_do", {24'h0, Do}, 32'd0);
        rdreg(2'd0);
        chk("rst_count", rdata, 32'd0);
        rdreg(2'd1);
        chk("rst_cmp", rdata, 32'hFF);
        rdreg(2'd2);
        chk("rst_ctrl", rdata, 32'h1);
        rdreg(2'd3);
        chk("rst_status", rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_mmio.md
# timer_mmio

Parametrised, memory-mapped successor to the free-running millisecond timer for the RISC32-SC system. It keeps the legacy behaviour: a prescaled tick counter with a one-cycle-registered `Do` output, counting milliseconds out of reset. It adds the following:
- configurable tick rate and width;
- a software-writable count;
- a compare register with optional auto-clear;
- overflow and match flags;
- a level interrupt to the core.

It sits on the data-memory bus beside the other MMIO peripherals.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `TICK_HZ`, 1_000: count rate. `DIV = CLK_HZ/TICK_HZ`. Elaboration error if `DIV < 2` or `CLK_HZ % TICK_HZ != 0`.
- `WIDTH`, 32: counter/compare width, 8..32. Bus fields are zero-extended to 32 bits.
- `CLK` in 1: system clock, all logic on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `sel` in 1: bus select for this block.
- `we` in 1: write strobe, valid only with `sel`.
- `addr` in 4: byte address. `addr[3:2]` selects the register; `addr[1:0]` is ignored.
- `wdata` in 32: write data.
- `rdata` out 32: registered read data.
- `irq` out 1: level interrupt, registered.
- `Do` out WIDTH: registered copy of COUNT (legacy output).

## Operation
Registers, selected by `addr[3:2]`:
- 0 COUNT, R/W.
- 1 CMP, R/W.
- 2 CTRL, R/W, bits [3:0]:
  - `EN` bit 0;
  - `CLR_ON_MATCH` bit 1;
  - `MIE` bit 2;
  - `OIE` bit 3;
  - upper bits read 0.
- 3 STATUS, bits [1:0]: `MATCH` bit 0, `OVF` bit 1. Write-1-to-clear; a write of 0 has no effect.

Reset values:
- COUNT = 0, CMP = all-ones, CTRL = 4'b0001 (free-running, as legacy), STATUS = 0.
- `rdata` = 0, `irq` = 0, `Do` = 0.

Prescaler:
- `pre` counts 0..DIV-1 while `EN=1`, then wraps to 0.
- `tick = EN && pre == DIV-1`.
- `EN=0` freezes both `pre` and COUNT.

On a tick:
- If COUNT == CMP:
  - set MATCH;
  - next COUNT = 0 if `CLR_ON_MATCH`, else normal increment.
- Normal increment is COUNT+1 modulo 2^WIDTH.
- A wrap from all-ones to 0 by increment sets OVF.
- A clear-on-match to 0 does not set OVF.
- CMP = all-ones with `CLR_ON_MATCH=1` sets MATCH only, not OVF.

Interrupt: `irq <= (MATCH & MIE) | (OVF & OIE)`, registered.

Boundary rules:
- **COUNT write and tick in the same cycle:** the write wins and `pre` is cleared to 0. The first tick after the write comes DIV cycles later.
- **Flag set and W1C in the same cycle:** set wins and the flag stays 1.
- **Write to CMP:** takes effect for the next tick's compare.
- **Writing `EN` 1→0:** holds `pre`. Re-enabling resumes from the held `pre` value.
- **Reset mid-count:** all state returns to reset values on the next edge, regardless of bus activity.

## Timing
- **Tick cadence:** with `EN=1`, ticks are exactly DIV cycles apart. COUNT updates on the edge where `tick=1`.
- **`Do`:** equals COUNT delayed by one cycle.
- **`irq`:** asserts one cycle after the flag sets, and deasserts one cycle after the flag is cleared or its enable is dropped.
- **Reads:** `sel & !we` at edge N gives `rdata` valid after edge N, holding the value sampled at edge N. `rdata` holds its value when there is no read.
- **Writes:** take effect at the write edge. A read in the next cycle returns the written value (COUNT: the written value unless a tick intervenes).
- **After reset release:** the first tick occurs DIV cycles after the first non-reset edge.

## Structure
- Package `timer_pkg` holds:
  - register offsets: `TMR_COUNT=0`, `TMR_CMP=1`, `TMR_CTRL=2`, `TMR_STATUS=3`;
  - CTRL bit indices: `EN`, `CLR_ON_MATCH`, `MIE`, `OIE`;
  - STATUS bit indices: `MATCH`, `OVF`.
- Sub-module `timer_prescaler` (parameter DIV):
  - inputs `CLK`, `RESET`, `en`, `clr`;
  - output `tick`;
  - holds `pre`, sized `$clog2(DIV)`.
- The top level holds the registers, compare logic, bus decode and irq.

## Test plan
Bench uses `CLK_HZ=10`, `TICK_HZ=1`, so DIV=10.
- **Reset default:** release reset, run 35 cycles. Expect COUNT=3, `Do` lagging COUNT by one cycle, `irq=0`.
- **Match with clear:** write CMP=2 and CTRL=4'b0111. Expect COUNT sequence 0,1,2,0; MATCH=1; `irq=1` one cycle after the match tick. W1C STATUS=1, expect `irq=0` one cycle later.
- **Overflow:** with WIDTH=8, write COUNT=8'hFF and CTRL=4'b1001. After 10 cycles expect COUNT=0, OVF=1, MATCH=1 (CMP=FF), `irq=1`.
- **Collisions:** write COUNT=5 on the tick edge. Expect COUNT=5, with the next increment exactly 10 cycles later. W1C MATCH on the same edge as a new match: MATCH stays 1.
- **Disable/resume:** clear EN mid-period at `pre=4` and hold 20 cycles; COUNT is unchanged. Re-enable; the next tick comes 6 cycles later.
- **Reset mid-operation:** assert RESET while `irq=1` and a read is pending. Expect all registers, `rdata`, `irq` and `Do` at reset values on the next edge.
